uart_tx: RTL and testbench

- Byte-oriented UART transmitter with a valid/ready input interface and a serial output line.
- It accepts a DATA_WIDTH-bit word from an upstream producer (sensor path) whenever idle.
- It serialises the word as 8N1-style: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
- Each bit is held for CLK_FREQ/BAUD_RATE clock cycles.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_baud_tick.sv | 25 ++
 rtl/uart_tx.sv | 96 +++++++++
 tb/tb_uart_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Clock cycles per bit; the truncation error is deliberately left uncorrected.
  function automatic int calc_bit_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick every BIT_CYCLES cycles while enabled,
// held at zero while disabled so every bit starts from a fresh count.
module uart_baud_tick #(
  parameter int BIT_CYCLES = 868
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rstn || !i_en)     r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word intake, 1 start + DATA_WIDTH data (LSB first)
// + 1 stop bit on tx_sig. Reset (rstn) is synchronous and active-high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_from_sensor,
  input  logic                  valid_from_sensor,
  output logic                  ready_to_sensor,
  output logic                  tx_sig
);

  localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  if (BIT_CYCLES < 2) begin : g_bad_rate
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  uart_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IW-1:0]         r_bit_idx;
  logic                  r_tx;
  logic                  r_ready;
  logic                  w_busy;
  logic                  w_tick;

  assign w_busy = (r_state != IDLE);

  uart_baud_tick #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (w_busy),
    .o_tick (w_tick)
  );

  // r_shift always holds the not-yet-sent bits, so bit 0 is the next one out.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (valid_from_sensor && r_ready) begin
            r_shift   <= data_from_sensor;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_ready   <= 1'b0;
            r_state   <= START;
          end else begin
            r_ready <= 1'b1;
          end
        end
        START: if (w_tick) begin
          r_tx    <= r_shift[0];
          r_shift <= r_shift >> 1;
          r_state <= DATA;
        end
        DATA: if (w_tick) begin
          if (r_bit_idx == LAST_BIT) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end else begin
            r_bit_idx <= r_bit_idx + 1'b1;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
          end
        end
        STOP: if (w_tick) begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready_to_sensor = r_ready;
  assign tx_sig          = r_tx;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: a cycle-position line model plus a serial
// receiver that pops expected words from a scoreboard queue.
module tb_uart_tx;

  localparam int DW    = 8;
  localparam int BAUD  = 100_000;
  localparam int CLKF  = 1_000_000;
  localparam int BC    = CLKF / BAUD;
  localparam int FRAME = (DW + 2) * BC;

  logic          clk = 1'b0;
  logic          rstn;
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;
  logic          tx_sig;

  uart_tx #(.DATA_WIDTH(DW), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .data_from_sensor  (data),
    .valid_from_sensor (valid),
    .ready_to_sensor   (ready),
    .tx_sig            (tx_sig)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [DW-1:0] exp_q[$];

  function automatic logic frame_bit(input logic [DW-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    return 1'b1;
  endfunction

  // Line model: m_pos is the 1-based cycle within the frame, 0 when idle.
  int            m_pos = 0;
  logic          m_tx = 1'b1;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_word = '0;
  bit            started = 0;
  int            n_hs = 0;
  int            n_abort = 0;

  always @(negedge clk) begin
    if (started) begin
      n_checks++;
      if (tx_sig !== m_tx || ready !== m_ready) begin
        n_errors++;
        $display("FAIL line cyc=%0d: got tx=%b ready=%b, expected tx=%b ready=%b",
                 cyc, tx_sig, ready, m_tx, m_ready);
      end
    end
    if (rstn) begin
      if (m_pos != 0) n_abort++;
      m_pos = 0; m_tx = 1'b1; m_ready = 1'b0; started = 1;
      exp_q.delete();
    end else if (m_pos == 0) begin
      if (valid && m_ready) begin
        m_word = data; exp_q.push_back(data); n_hs++;
        m_pos = 1; m_tx = 1'b0; m_ready = 1'b0;
      end else begin
        m_tx = 1'b1; m_ready = 1'b1;
      end
    end else if (m_pos == FRAME) begin
      m_pos = 0; m_tx = 1'b1; m_ready = 1'b1;
    end else begin
      m_pos++;
      m_tx = frame_bit(m_word, (m_pos - 1) / BC);
    end
  end

  // Serial receiver: mid-bit sampling, pops the scoreboard on each stop bit.
  logic [DW-1:0] rx_data = '0;
  logic [DW-1:0] rx_exp;
  int  rx_cnt = 0;
  bit  rx_act = 0;
  int  rx_prev_start = -1;
  int  rx_gap = 0;
  int  n_rx = 0;

  always @(negedge clk) begin
    int b;
    if (rstn) rx_act = 0;
    else if (!rx_act) begin
      if (tx_sig === 1'b0) begin
        rx_act = 1; rx_cnt = 0; rx_data = '0;
        if (rx_prev_start >= 0) rx_gap = cyc - rx_prev_start;
        rx_prev_start = cyc;
      end
    end else rx_cnt++;
    if (rx_act && !rstn && (rx_cnt % BC) == BC / 2) begin
      b = rx_cnt / BC;
      if (b == 0) begin
        n_checks++;
        if (tx_sig !== 1'b0) begin
          n_errors++;
          $display("FAIL start_bit: got %b, expected 0", tx_sig);
        end
      end else if (b <= DW) begin
        rx_data[b-1] = tx_sig;
      end else begin
        n_checks++;
        if (tx_sig !== 1'b1) begin
          n_errors++;
          $display("FAIL stop_bit: got %b, expected 1", tx_sig);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL frame_data: got unexpected frame %h, expected none", rx_data);
        end else begin
          rx_exp = exp_q.pop_front();
          if (rx_data !== rx_exp) begin
            n_errors++;
            $display("FAIL frame_data: got %h, expected %h", rx_data, rx_exp);
          end
        end
        n_rx++;
        rx_act = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_hs(input string tag);
    int base = n_hs;
    int k = 0;
    while (n_hs == base && k < 4 * FRAME) begin step(1); k++; end
    n_checks++;
    if (n_hs == base) begin
      n_errors++;
      $display("FAIL %s: no handshake after %0d cycles, expected one", tag, k);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!(m_pos == 0 && m_ready) && k < 4 * FRAME) begin step(1); k++; end
    n_checks++;
    if (m_pos != 0 || !m_ready) begin
      n_errors++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", tag, k);
    end
  endtask

  initial begin
    rstn = 1'b1; valid = 1'b0; data = '0;
    step(3);
    rstn = 1'b0;
    step(50 * BC);

    // One frame; a second word offered while busy must wait.
    data = 8'hC3; valid = 1'b1; step(2 * BC); valid = 1'b0;
    data = 8'hB3; valid = 1'b1; step(5 * BC); valid = 1'b0;
    wait_idle("frame_c3");
    step(BC);
    valid = 1'b1; wait_hs("hs_b3"); valid = 1'b0;
    wait_idle("frame_b3");

    // Back-to-back with valid held continuously.
    data = 8'h5A; valid = 1'b1; wait_hs("hs_b2b_1");
    data = 8'h81; wait_hs("hs_b2b_2"); valid = 1'b0;
    wait_idle("frame_b2b");
    n_checks++;
    if (rx_gap != FRAME + 1) begin
      n_errors++;
      $display("FAIL b2b_gap: got %0d cycles, expected %0d", rx_gap, FRAME + 1);
    end

    // Reset in the middle of the data bits.
    step(BC);
    data = 8'hA5; valid = 1'b1; wait_hs("hs_a5"); valid = 1'b0;
    step(4 * BC);
    rstn = 1'b1; step(2); rstn = 1'b0;
    step(2);
    data = DW'($urandom); valid = 1'b1; wait_hs("hs_after_rst"); valid = 1'b0;
    wait_idle("frame_after_rst");

    // Random producer behaviour, including data changes while waiting.
    for (int i = 0; i < 10; i++) begin
      data = DW'($urandom); valid = 1'b1;
      step($urandom_range(1, 3 * BC));
      if ($urandom_range(0, 1) == 1) begin
        data = DW'($urandom);
        step($urandom_range(1, 2 * BC));
      end
      valid = 1'b0;
      step($urandom_range(0, 12 * BC));
    end
    valid = 1'b0;
    wait_idle("random_end");
    step(BC);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d words pending, expected 0", exp_q.size());
    end
    n_checks++;
    if (n_rx != n_hs - n_abort || n_abort != 1) begin
      n_errors++;
      $display("FAIL frame_count: got %0d frames (%0d aborted), expected %0d frames (1 aborted)",
               n_rx, n_abort, n_hs - 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
